// File: rtl/div_const_pkg.sv
// Shared constants and types for the constant-divisor reconstruction path.
// When DIV_RECON_CHECK_EN is defined, the stage payloads also carry the
// original dividend and the mismatch flag.
package div_const_pkg;

    // Ceiling log2. Used only in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int W_X  = 16;                    // dividend / result width
    localparam int D    = 3;                     // constant divisor, >= 2, not a power of two
    localparam int W_R  = clog2(D);              // remainder width
    localparam int W_Q  = W_X - (clog2(D) - 1);  // quotient width: W_X - floor(log2 D)
    localparam int W_P  = W_X + 2;               // product/sum width, leaves room to see overflow
    localparam int W_DB = clog2(D + 1);          // number of bits needed to hold D

    // D at remainder width. It fits because D is not a power of two.
    localparam logic [W_R-1:0] D_R = W_R'(D);

    // Payload held by the first stage: product, remainder and its legality flag
    typedef struct packed {
        logic [W_P-1:0] p;
        logic [W_R-1:0] r;
        logic           err;
`ifdef DIV_RECON_CHECK_EN
        logic [W_X-1:0] x_exp;
`endif
    } recon_stage_t;

    // Payload held by the output stage
    typedef struct packed {
        logic [W_X-1:0] x;
        logic           err;
        logic           ovf;
`ifdef DIV_RECON_CHECK_EN
        logic           mis;
`endif
    } recon_out_t;

endpackage

// File: rtl/div_recon_stage.sv
// One valid/ready register slice. The slice accepts new data when it is empty
// or when its own contents leave this cycle. Because of that, the ready output
// is combinational from i_ready.
module div_recon_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Load on every edge where the slice is free. Data is only replaced by a
    // valid word, so an idle slice keeps its last payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/div_const_recon.sv
// Rebuilds a dividend X = Q*D + R from a quotient/remainder pair.
// Stage 1 registers the product Q*D, the remainder and the flag for an illegal
// remainder. Stage 2 adds the remainder and registers the result and the
// overflow flag.
// The optional macro DIV_RECON_CHECK_EN adds a comparison against a carried
// expected dividend and a saturating mismatch counter.
module div_const_recon
    import div_const_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_Q-1:0] in_q,
    input  logic [W_R-1:0] in_r,
`ifdef DIV_RECON_CHECK_EN
    input  logic [W_X-1:0] in_x_exp,
    output logic           out_mis,
    output logic [15:0]    err_cnt,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_X-1:0] out_x,
    output logic           out_err,
    output logic           out_ovf
);

    logic [W_P-1:0] w_pp [0:W_DB-1];
    logic [W_P-1:0] w_p;
    logic [W_P-1:0] w_sum;
    recon_stage_t   w_s1_in;
    recon_stage_t   w_s1_q;
    recon_out_t     w_s2_in;
    recon_out_t     w_s2_q;
    logic           w_s1_valid;
    logic           w_s2_ready;

    // Shift-add multiply by the constant: one shifted copy of Q per set bit of D
    genvar gi;
    generate
        for (gi = 0; gi < W_DB; gi++) begin : g_pp
            if (((D >> gi) & 1) == 1) begin : g_on
                assign w_pp[gi] = W_P'(in_q) << gi;
            end else begin : g_off
                assign w_pp[gi] = '0;
            end
        end
    endgenerate

    // Sum the partial products
    always_comb begin
        w_p = '0;
        for (int k = 0; k < W_DB; k++) begin
            w_p = w_p + w_pp[k];
        end
    end

    // Build the stage-1 payload from the input pair
    always_comb begin
        w_s1_in       = '0;
        w_s1_in.p     = w_p;
        w_s1_in.r     = in_r;
        w_s1_in.err   = (in_r >= D_R);
`ifdef DIV_RECON_CHECK_EN
        w_s1_in.x_exp = in_x_exp;
`endif
    end

    div_recon_stage #(
        .W($bits(recon_stage_t))
    ) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_q)
    );

    // Add the remainder. An illegal remainder is still added, and its flag
    // travels with this one result.
    always_comb begin
        w_sum       = w_s1_q.p + W_P'(w_s1_q.r);
        w_s2_in     = '0;
        w_s2_in.x   = w_sum[W_X-1:0];
        w_s2_in.err = w_s1_q.err;
        w_s2_in.ovf = |w_sum[W_P-1:W_X];
`ifdef DIV_RECON_CHECK_EN
        w_s2_in.mis = (w_sum[W_X-1:0] != w_s1_q.x_exp) || w_s1_q.err
                      || (|w_sum[W_P-1:W_X]);
`endif
    end

    div_recon_stage #(
        .W($bits(recon_out_t))
    ) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_q)
    );

    assign out_x   = w_s2_q.x;
    assign out_err = w_s2_q.err;
    assign out_ovf = w_s2_q.ovf;

`ifdef DIV_RECON_CHECK_EN
    logic [15:0] r_err_cnt;

    assign out_mis = out_valid && w_s2_q.mis;
    assign err_cnt = r_err_cnt;

    // Count mismatching results as they leave. The count holds at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (out_valid && out_ready && w_s2_q.mis && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_div_const_recon.sv
// Directed testbench for div_const_recon. It covers single pairs with known
// results, illegal remainders, overflow, backpressure with in-order delivery,
// and reset while entries are in flight. When DIV_RECON_CHECK_EN is defined it
// also covers the mismatch flag and the saturating counter.
module tb_div_const_recon;
    import div_const_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W_Q-1:0] in_q;
    logic [W_R-1:0] in_r;
    logic           out_valid;
    logic           out_ready;
    logic [W_X-1:0] out_x;
    logic           out_err;
    logic           out_ovf;
`ifdef DIV_RECON_CHECK_EN
    logic [W_X-1:0] in_x_exp;
    logic           out_mis;
    logic [15:0]    err_cnt;
`endif

    int n_err   = 0;
    int n_chk   = 0;
    int exp_cnt = 0;

    div_const_recon dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_r      (in_r),
`ifdef DIV_RECON_CHECK_EN
        .in_x_exp  (in_x_exp),
        .out_mis   (out_mis),
        .err_cnt   (err_cnt),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_err   (out_err),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pair through an idle pipe with out_ready high. out_valid must be
    // low after the accept edge and high one edge later.
    task automatic send_one(input string tag, input int q, input int r, input int xexp,
                            input int ex, input int ee, input int eo);
        int mis;
        @(negedge clk);
        in_valid  = 1'b1;
        in_q      = W_Q'(q);
        in_r      = W_R'(r);
        out_ready = 1'b1;
`ifdef DIV_RECON_CHECK_EN
        in_x_exp  = W_X'(xexp);
`endif
        #1 chk({tag, ".in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".lat1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".x"}, out_x, ex);
        chk({tag, ".err"}, out_err, ee);
        chk({tag, ".ovf"}, out_ovf, eo);
        mis = ((ex != xexp) || (ee != 0) || (eo != 0)) ? 1 : 0;
`ifdef DIV_RECON_CHECK_EN
        chk({tag, ".mis"}, out_mis, mis);
        chk({tag, ".cnt"}, err_cnt, exp_cnt);
        if (mis != 0 && exp_cnt != 65535) exp_cnt++;
`endif
        $display("txn %s q=%0d r=%0d x=%0d err=%0b ovf=%0b mis=%0d", tag, q, r, out_x, out_err, out_ovf, mis);
    endtask

`ifdef DIV_RECON_CHECK_EN
    // Stream n pairs whose expected dividend is wrong, back to back, then drain
    task automatic stream_bad(input int n);
        @(negedge clk);
        in_valid  = 1'b1;
        in_q      = '0;
        in_r      = '0;
        in_x_exp  = W_X'(1);
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        int sent;
        int rcv;
        int occ;
        int max_occ;
        int acc;
        int emit;
        int seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_q      = '0;
        in_r      = '0;
        out_ready = 1'b0;
`ifdef DIV_RECON_CHECK_EN
        in_x_exp  = '0;
`endif
        #1;
        chk("rst.valid", out_valid, 0);
        chk("rst.x", out_x, 0);
        chk("rst.err", out_err, 0);
        chk("rst.ovf", out_ovf, 0);
`ifdef DIV_RECON_CHECK_EN
        chk("rst.cnt", err_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst.in_ready", in_ready, 1);

        // Directed pairs: tag, q, r, expected dividend, x, err, ovf
        send_one("max",    21845, 0, 65535, 65535, 0, 0);
        send_one("wrap",   21845, 1, 0,     0,     0, 1);
        send_one("q0r2",   0,     2, 2,     2,     0, 0);
        send_one("q1r1",   1,     1, 4,     4,     0, 0);
        send_one("qmax",   32767, 2, 32767, 32767, 0, 1);
        send_one("badr",   5,     3, 18,    18,    1, 0);
        send_one("okafter",1,     1, 4,     4,     0, 0);
        send_one("chk100", 33,    1, 100,   100,   0, 0);
        send_one("chk101", 33,    1, 101,   100,   0, 0);

        // Backpressure: 10 pairs streamed, out_ready low for 4 cycles
        sent = 0; rcv = 0; occ = 0; max_occ = 0;
        for (int c = 0; c < 60 && rcv < 10; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c < 7);
            in_valid  = (sent < 10);
            in_q      = W_Q'(sent + 100);
            in_r      = W_R'(sent % 3);
`ifdef DIV_RECON_CHECK_EN
            in_x_exp  = W_X'((sent + 100) * 3 + sent % 3);
`endif
            #1;
            chk("bp.in_ready", in_ready, (occ == 2 && !out_ready) ? 0 : 1);
            acc  = (in_valid && in_ready) ? 1 : 0;
            emit = (out_valid && out_ready) ? 1 : 0;
            if (emit != 0) begin
                chk("bp.x", out_x, (rcv + 100) * 3 + rcv % 3);
                $display("txn bp idx=%0d x=%0d", rcv, out_x);
                rcv++;
            end
            if (acc != 0) sent++;
            occ = occ + acc - emit;
            if (occ > max_occ) max_occ = occ;
        end
        in_valid = 1'b0;
        chk("bp.count", rcv, 10);
        chk("bp.max_occ", max_occ, 2);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("bp.no_extra", seen, 0);

        // Reset with two entries in flight
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_q      = W_Q'(7);
        in_r      = '0;
        @(negedge clk);
        in_q = W_Q'(8);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid.in_ready", in_ready, 0);
        chk("mid.valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.rst_valid", out_valid, 0);
        chk("mid.rst_x", out_x, 0);
`ifdef DIV_RECON_CHECK_EN
        chk("mid.rst_cnt", err_cnt, 0);
`endif
        exp_cnt = 0;
        $display("txn reset in flight");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("mid.no_emit", seen, 0);

`ifdef DIV_RECON_CHECK_EN
        // Counter saturation
        stream_bad(65534);
        chk("sat.below", err_cnt, 65534);
        $display("txn sat count=%0d", err_cnt);
        stream_bad(6);
        chk("sat.hold", err_cnt, 65535);
        $display("txn sat count=%0d", err_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
